// File: rtl/csi2_dphy_delay_cal.sv
// Per-lane IDELAY calibration for the CSI-2 D-PHY receiver: sweeps every tap, scores sync
// detections against sync errors, then centres each lane in its widest passing window.
module csi2_dphy_delay_cal #(
  parameter int DATA_LANES = 2,
  parameter int TAP_COUNT  = 32,
  parameter int SETTLE_LEN = 16,
  parameter int WINDOW_LEN = 4096,
  parameter int MIN_SYNC   = 2,
  localparam int TW        = $clog2(TAP_COUNT)
) (
  input  logic                       ref_clk_i,
  input  logic                       ref_srst_i,
  input  logic                       start_i,
  input  logic [DATA_LANES-1:0]      lane_sync_i,
  input  logic [DATA_LANES-1:0]      lane_sync_err_i,
  input  logic [DATA_LANES-1:0]      btn_i,
  output logic [DATA_LANES-1:0]      inc_delay_o,
  output logic [DATA_LANES*TW-1:0]   tap_o,
  output logic                       busy_o,
  output logic                       done_o,
  output logic [DATA_LANES-1:0]      fail_o
);

  localparam int LW      = TW + 1;
  localparam int CNT_MAX = (WINDOW_LEN > SETTLE_LEN) ? WINDOW_LEN : SETTLE_LEN;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [TW-1:0] LAST_TAP    = TW'(TAP_COUNT - 1);
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_LEN - 1);
  localparam logic [CW-1:0] WINDOW_LAST = CW'(WINDOW_LEN - 1);
  localparam logic [7:0]    SYNC_MIN    = 8'(MIN_SYNC);

  typedef enum logic [2:0] {
    S_IDLE, S_REWIND, S_SETTLE, S_MEASURE, S_EVAL, S_STEP, S_CENTER, S_DONE
  } state_t;

  state_t                               r_state, w_state_nxt;
  logic [CW-1:0]                        r_cnt;
  logic [TW-1:0]                        r_k;
  logic                                 r_gap, r_busy, r_done;
  logic [DATA_LANES-1:0][TW-1:0]        r_tap, r_cur_start, r_best_start, w_target;
  logic [DATA_LANES-1:0][LW-1:0]        r_cur_len, r_best_len, w_center, w_run_len;
  logic [DATA_LANES-1:0][TW-1:0]        w_run_start;
  logic [DATA_LANES-1:0][7:0]           r_sync_cnt;
  logic [DATA_LANES-1:0]                r_err, r_inc, r_fail;
  logic [DATA_LANES-1:0]                w_inc, w_pass, w_tap_match, w_btn_edge;
  logic [3:0][DATA_LANES-1:0]           r_btn_sync;
  logic                                 w_accept, w_meas_start;

  function automatic logic [TW-1:0] next_tap(input logic [TW-1:0] t);
    return (t == LAST_TAP) ? '0 : t + 1'b1;
  endfunction

  assign w_btn_edge   = r_btn_sync[2] & ~r_btn_sync[3];
  assign w_accept     = start_i && (r_state == S_IDLE || r_state == S_DONE);
  assign w_meas_start = (r_state == S_SETTLE) && (r_cnt == SETTLE_LAST);

  always_comb begin
    for (int l = 0; l < DATA_LANES; l++) begin
      w_pass[l]      = (r_sync_cnt[l] >= SYNC_MIN) && !r_err[l];
      w_run_start[l] = (r_cur_len[l] == '0) ? r_k : r_cur_start[l];
      w_run_len[l]   = r_cur_len[l] + 1'b1;
      // Runs never wrap, so the centre always stays below TAP_COUNT and truncation is safe.
      w_center[l]    = {1'b0, r_best_start[l]} + ((r_best_len[l] - LW'(1)) >> 1);
      w_target[l]    = (r_best_len[l] == '0) ? '0 : w_center[l][TW-1:0];
      w_tap_match[l] = (r_tap[l] == w_target[l]);
    end
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_inc       = '0;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          w_state_nxt = S_REWIND;
          for (int l = 0; l < DATA_LANES; l++) w_inc[l] = (r_tap[l] != '0);
        end else begin
          w_inc = w_btn_edge;
        end
      end
      S_REWIND: begin
        for (int l = 0; l < DATA_LANES; l++) w_inc[l] = !r_gap && (r_tap[l] != '0);
        if (r_tap == '0) w_state_nxt = S_SETTLE;
      end
      S_SETTLE:  if (r_cnt == SETTLE_LAST) w_state_nxt = S_MEASURE;
      S_MEASURE: if (r_cnt == WINDOW_LAST) w_state_nxt = S_EVAL;
      S_EVAL:    w_state_nxt = S_STEP;
      S_STEP: begin
        w_inc       = '1;
        w_state_nxt = (r_k == LAST_TAP) ? S_CENTER : S_SETTLE;
      end
      S_CENTER: begin
        for (int l = 0; l < DATA_LANES; l++) w_inc[l] = !r_gap && !w_tap_match[l];
        if (&w_tap_match) w_state_nxt = S_DONE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge ref_clk_i or posedge ref_srst_i) begin
    if (ref_srst_i) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_k          <= '0;
      r_gap        <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_tap        <= '0;
      r_cur_start  <= '0;
      r_best_start <= '0;
      r_cur_len    <= '0;
      r_best_len   <= '0;
      r_sync_cnt   <= '0;
      r_err        <= '0;
      r_inc        <= '0;
      r_fail       <= '0;
      r_btn_sync   <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= (w_state_nxt != r_state) ? '0 : r_cnt + 1'b1;
      r_inc      <= w_inc;
      r_gap      <= |w_inc;
      r_btn_sync <= {r_btn_sync[2:0], btn_i};
      for (int l = 0; l < DATA_LANES; l++) begin
        if (w_inc[l]) r_tap[l] <= next_tap(r_tap[l]);
        // The counters restart on the SETTLE->MEASURE edge but still count that cycle's pulses.
        if (w_meas_start) begin
          r_sync_cnt[l] <= {7'd0, lane_sync_i[l]};
          r_err[l]      <= lane_sync_err_i[l];
        end else if (r_state == S_MEASURE) begin
          if (lane_sync_i[l] && r_sync_cnt[l] != 8'hFF) r_sync_cnt[l] <= r_sync_cnt[l] + 1'b1;
          if (lane_sync_err_i[l]) r_err[l] <= 1'b1;
        end
        if (r_state == S_EVAL) begin
          if (w_pass[l]) begin
            r_cur_start[l] <= w_run_start[l];
            r_cur_len[l]   <= w_run_len[l];
            if (w_run_len[l] > r_best_len[l]) begin
              r_best_start[l] <= w_run_start[l];
              r_best_len[l]   <= w_run_len[l];
            end
          end else begin
            r_cur_len[l] <= '0;
          end
        end
        if (r_state == S_CENTER) r_fail[l] <= (r_best_len[l] == '0);
      end
      if (r_state == S_STEP && r_k != LAST_TAP) r_k <= r_k + 1'b1;
      if (r_state == S_CENTER && w_state_nxt == S_DONE) begin
        r_busy <= 1'b0;
        r_done <= 1'b1;
      end
      if (w_accept) begin
        r_busy       <= 1'b1;
        r_done       <= 1'b0;
        r_fail       <= '0;
        r_k          <= '0;
        r_cur_start  <= '0;
        r_cur_len    <= '0;
        r_best_start <= '0;
        r_best_len   <= '0;
      end
    end
  end

  assign inc_delay_o = r_inc;
  assign tap_o       = r_tap;
  assign busy_o      = r_busy;
  assign done_o      = r_done;
  assign fail_o      = r_fail;

endmodule

// File: tb/tb_csi2_dphy_delay_cal.sv
// Randomized self-checking bench for csi2_dphy_delay_cal: an emulated receiver produces sync
// traffic from per-lane pass masks; expected taps come from a brute-force widest-window search.
module tb_csi2_dphy_delay_cal;

  localparam int LANES  = 2;
  localparam int TAPS   = 32;
  localparam int TW     = 5;
  localparam int SETTLE = 4;
  localparam int WINDOW = 24;

  logic             ref_clk_i = 1'b0;
  logic             ref_srst_i;
  logic             start_i;
  logic [LANES-1:0] lane_sync_i, lane_sync_err_i, btn_i;
  logic [LANES-1:0] inc_delay_o, fail_o;
  logic [LANES*TW-1:0] tap_o;
  logic             busy_o, done_o;

  int n_total = 0;
  int n_bad   = 0;
  int pulse_cnt [LANES];
  int spacing_viol = 0;
  logic [31:0] mask [LANES];
  int err_tap [LANES];
  int exp_tap [LANES];

  csi2_dphy_delay_cal #(
    .DATA_LANES(LANES), .TAP_COUNT(TAPS), .SETTLE_LEN(SETTLE),
    .WINDOW_LEN(WINDOW), .MIN_SYNC(2)
  ) dut (
    .ref_clk_i(ref_clk_i), .ref_srst_i(ref_srst_i), .start_i(start_i),
    .lane_sync_i(lane_sync_i), .lane_sync_err_i(lane_sync_err_i), .btn_i(btn_i),
    .inc_delay_o(inc_delay_o), .tap_o(tap_o), .busy_o(busy_o), .done_o(done_o),
    .fail_o(fail_o)
  );

  always #5 ref_clk_i = ~ref_clk_i;

  task automatic check(input string tag, input int got, input int exp);
    n_total++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] range_mask(input int lo, input int hi);
    logic [31:0] m;
    m = '0;
    for (int i = lo; i <= hi; i++) m[i] = 1'b1;
    return m;
  endfunction

  // Widest all-pass span with no wrap; the earliest start wins among equal widths.
  function automatic int exp_target(input logic [31:0] m, output bit f);
    bit ok_run;
    for (int len = TAPS; len >= 1; len--) begin
      for (int s = 0; s + len <= TAPS; s++) begin
        ok_run = 1'b1;
        for (int i = s; i < s + len; i++) if (!m[i]) ok_run = 1'b0;
        if (ok_run) begin
          f = 1'b0;
          return s + (len - 1) / 2;
        end
      end
    end
    f = 1'b1;
    return 0;
  endfunction

  // Sync slots sit inside the measurement window; failing taps may also get pulses in SETTLE.
  function automatic logic [31:0] make_sync_sched(input bit pass);
    logic [31:0] s;
    int n;
    s = '0;
    n = pass ? $urandom_range(3, 2) : $urandom_range(1, 0);
    for (int j = 0; j < n; j++) s[6 + j * 7 + $urandom_range(5, 0)] = 1'b1;
    if (!pass && $urandom_range(1, 0) == 1) s[1:0] = 2'b11;
    return s;
  endfunction

  // Emulated receiver: traffic quality follows the tap the DUT currently applies.
  initial begin
    int c [LANES];
    logic [31:0] ss [LANES];
    logic [31:0] es [LANES];
    logic [TW-1:0] t;
    bit pass, prev_busy;
    for (int l = 0; l < LANES; l++) begin
      c[l] = 99; ss[l] = '0; es[l] = '0;
    end
    prev_busy = 1'b0;
    forever begin
      @(negedge ref_clk_i);
      for (int l = 0; l < LANES; l++) begin
        if (inc_delay_o[l] || (busy_o && !prev_busy)) begin
          c[l]  = 0;
          t     = tap_o[l*TW +: TW];
          pass  = mask[l][t];
          ss[l] = make_sync_sched(pass);
          es[l] = '0;
          if (int'(t) == err_tap[l]) es[l][16] = 1'b1;
          else if (!pass && $urandom_range(1, 0) == 1) es[l][12] = 1'b1;
        end else if (c[l] < 99) begin
          c[l]++;
        end
        lane_sync_i[l]     = (c[l] < 32) && ss[l][c[l]];
        lane_sync_err_i[l] = (c[l] < 32) && es[l][c[l]];
      end
      prev_busy = busy_o;
    end
  end

  // Pulse counter and width/spacing monitor.
  initial begin
    logic [LANES-1:0] prev;
    prev = '0;
    forever begin
      @(negedge ref_clk_i);
      for (int l = 0; l < LANES; l++) begin
        if (inc_delay_o[l]) begin
          pulse_cnt[l]++;
          if (prev[l]) spacing_viol++;
        end
      end
      prev = inc_delay_o;
    end
  end

  task automatic run_cal(input string tag, input logic [31:0] m0, input logic [31:0] m1,
                         input int e0, input int e1, input int btn_at);
    int tgt [LANES];
    bit f [LANES];
    int base [LANES];
    int rew, n;
    logic [31:0] eff;
    logic [LANES-1:0] exp_first, exp_fail;
    mask[0] = m0; mask[1] = m1;
    err_tap[0] = e0; err_tap[1] = e1;
    exp_first = '0; exp_fail = '0;
    for (int l = 0; l < LANES; l++) begin
      eff = mask[l];
      if (err_tap[l] >= 0) eff[err_tap[l]] = 1'b0;
      tgt[l] = exp_target(eff, f[l]);
      exp_fail[l] = f[l];
      exp_first[l] = (exp_tap[l] != 0);
      base[l] = pulse_cnt[l];
    end
    start_i = 1'b1;
    @(negedge ref_clk_i);
    start_i = 1'b0;
    check({tag, "/busy_rise"}, int'(busy_o), 1);
    check({tag, "/first_inc"}, int'(inc_delay_o), int'(exp_first));
    n = 0;
    while (!done_o && n < 4000) begin
      if (n == btn_at) btn_i[0] = 1'b1;
      if (n == btn_at + 6) btn_i[0] = 1'b0;
      @(negedge ref_clk_i);
      n++;
    end
    btn_i = '0;
    check({tag, "/done"}, int'(done_o), 1);
    check({tag, "/busy_end"}, int'(busy_o), 0);
    check({tag, "/fail"}, int'(fail_o), int'(exp_fail));
    for (int l = 0; l < LANES; l++) begin
      rew = (exp_tap[l] == 0) ? 0 : TAPS - exp_tap[l];
      check($sformatf("%s/tap%0d", tag, l), int'(tap_o[l*TW +: TW]), tgt[l]);
      check($sformatf("%s/pulses%0d", tag, l), pulse_cnt[l] - base[l], rew + TAPS + tgt[l]);
      exp_tap[l] = tgt[l];
    end
  endtask

  initial begin
    logic [31:0] r0, r1;
    int lo, lat, b0, b1;
    pulse_cnt[0] = 0; pulse_cnt[1] = 0;
    mask[0] = '0; mask[1] = '0;
    err_tap[0] = -1; err_tap[1] = -1;
    exp_tap[0] = 0; exp_tap[1] = 0;
    ref_srst_i = 1'b1; start_i = 1'b0; btn_i = '0;
    lane_sync_i = '0; lane_sync_err_i = '0;
    repeat (3) @(negedge ref_clk_i);
    ref_srst_i = 1'b0;
    @(negedge ref_clk_i);
    check("reset/tap", int'(tap_o), 0);
    check("reset/busy", int'(busy_o), 0);
    check("reset/done", int'(done_o), 0);
    check("reset/fail", int'(fail_o), 0);
    check("reset/inc", int'(inc_delay_o), 0);

    run_cal("single", range_mask(10, 20), range_mask(0, 31), -1, -1, -1);
    run_cal("two_win", range_mask(2, 4) | range_mask(8, 10),
            range_mask(3, 5) | range_mask(20, 29), -1, -1, -1);
    run_cal("err_kill", range_mask(10, 20), $urandom() | range_mask(4, 9), 15, -1, -1);
    run_cal("no_sync", 32'h0, range_mask(6, 17) | ($urandom() & $urandom()), -1, -1, -1);
    for (int i = 0; i < 3; i++) begin
      lo = $urandom_range(28, 0);
      r0 = ($urandom() & $urandom()) | range_mask(lo, (lo + 8 > 31) ? 31 : lo + 8);
      r1 = $urandom();
      run_cal($sformatf("rand%0d", i), r0, r1, $urandom_range(31, 0), -1, -1);
    end

    // Asynchronous reset in the middle of a sweep.
    mask[0] = range_mask(5, 25); mask[1] = range_mask(0, 31);
    start_i = 1'b1;
    @(negedge ref_clk_i);
    start_i = 1'b0;
    repeat (100) @(negedge ref_clk_i);
    #2 ref_srst_i = 1'b1;
    #1;
    check("midrst/tap", int'(tap_o), 0);
    check("midrst/busy", int'(busy_o), 0);
    check("midrst/done", int'(done_o), 0);
    check("midrst/inc", int'(inc_delay_o), 0);
    repeat (2) @(negedge ref_clk_i);
    ref_srst_i = 1'b0;
    exp_tap[0] = 0; exp_tap[1] = 0;
    repeat (3) @(negedge ref_clk_i);
    check("midrst/idle", int'(busy_o), 0);

    // Button while busy is dropped; pulse totals must stay exact.
    run_cal("btn_busy", range_mask(12, 19), range_mask(1, 30), -1, -1, 300);

    // Button in DONE: one pulse after synchroniser plus register latency.
    b0 = pulse_cnt[0]; b1 = pulse_cnt[1];
    btn_i[1] = 1'b1;
    lat = 0;
    do begin
      @(negedge ref_clk_i);
      lat++;
    end while (!inc_delay_o[1] && lat < 10);
    check("btn_done/latency", lat, 4);
    repeat (8) @(negedge ref_clk_i);
    btn_i[1] = 1'b0;
    repeat (8) @(negedge ref_clk_i);
    check("btn_done/pulses1", pulse_cnt[1] - b1, 1);
    check("btn_done/pulses0", pulse_cnt[0] - b0, 0);
    check("btn_done/tap1", int'(tap_o[TW +: TW]), (exp_tap[1] + 1) % TAPS);
    check("btn_done/done", int'(done_o), 1);

    check("inc_spacing", spacing_viol, 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/csi2_dphy_delay_cal.md
# csi2_dphy_delay_cal

Automatic per-lane input-delay calibration for the CSI-2 D-PHY receiver, running in the ref_clk_i domain. It produces the `inc_delay` pulses that the receiver's IDELAY taps consume, replacing the push-button stepping used during bring-up. It sweeps every tap, scores each tap by HS sync-byte (0xB8) detections versus sync errors, then moves each lane to the centre of its widest passing window. Manual button stepping remains available when the block is not busy.

## Interface
- DATA_LANES, 2, number of D-PHY data lanes.
- TAP_COUNT, 32, IDELAY taps per lane; incrementing past the last tap wraps to 0. TW = $clog2(TAP_COUNT).
- SETTLE_LEN, 16, cycles ignored after each tap change.
- WINDOW_LEN, 4096, measurement cycles per tap.
- MIN_SYNC, 2, sync detections a tap needs to pass.

Ports:
- ref_clk_i  in  1  clock.
- ref_srst_i  in  1  reset, asynchronous, active-high.
- start_i  in  1  one-cycle calibration request; ignored while busy_o=1.
- lane_sync_i  in  DATA_LANES  one-cycle pulse per lane on a correct 0xB8 sync byte.
- lane_sync_err_i  in  DATA_LANES  one-cycle pulse per lane on a corrupted sync byte.
- btn_i  in  DATA_LANES  raw asynchronous manual-step buttons.
- inc_delay_o  out  DATA_LANES  registered one-cycle tap-increment pulses.
- tap_o  out  DATA_LANES*TW  current tap per lane; lane n occupies bits [n*TW +: TW].
- busy_o  out  1  high from the start_i acceptance through the last CENTER pulse.
- done_o  out  1  calibration complete.
- fail_o  out  DATA_LANES  set when a lane has no passing tap.

## Operation
- Reset values: all outputs 0, tap_o=0, FSM in IDLE. After reset the IDELAY is also at tap 0.
- **Buttons**
  - Each button passes through a 3-flop synchroniser. A rising edge gives one inc_delay_o pulse on that lane and tap_o+1 mod TAP_COUNT.
  - Edges are honoured only in IDLE and DONE and are dropped otherwise.
- **FSM states:** IDLE, REWIND, SETTLE, MEASURE, EVAL, STEP, CENTER, DONE.
- **IDLE / DONE**
  - start_i moves to REWIND.
  - Entering REWIND clears done_o and fail_o, sets busy_o, and clears the per-lane best and current run trackers and sweep index k.
- **REWIND**
  - Each lane with tap_o≠0 pulses until its tap wraps to 0, at most one pulse every 2 cycles (pulse, gap).
  - When all taps are 0, go to SETTLE.
- **SETTLE:** SETTLE_LEN cycles, then go to MEASURE with the per-lane counters cleared.
- **MEASURE**
  - Lasts WINDOW_LEN cycles.
  - Per lane: sync_cnt is an 8-bit saturating count of lane_sync_i; err_flag is sticky on lane_sync_err_i.
  - Pulses in the same cycle as SETTLE→MEASURE are counted. Pulses outside MEASURE are ignored.
- **EVAL** (1 cycle), per lane:
  - pass = (sync_cnt ≥ MIN_SYNC) && !err_flag.
  - If pass: when cur_len==0, set cur_start=k; then cur_len+1. If the new cur_len > best_len (strictly greater), copy cur_start and cur_len into best.
  - If fail: cur_len=0.
  - Runs do not merge across the wrap from TAP_COUNT-1 to 0. On ties, the earliest run wins.
- **STEP** (1 cycle)
  - All lanes receive one inc_delay_o pulse and tap_o increments.
  - If k==TAP_COUNT-1, taps wrap to 0 and the FSM goes to CENTER. Otherwise k+1 and the FSM goes to SETTLE.
- **CENTER**
  - Per lane, target = best_start + (best_len-1)>>1.
  - If best_len==0: target=0 and fail_o[lane] is set.
  - Each lane pulses, one pulse every 2 cycles, until tap_o==target. When all lanes match, go to DONE.
- **DONE:** done_o=1, busy_o=0; fail_o and tap_o hold.
- **Reset mid-operation:** everything returns to reset values immediately; the IDELAY must be reset alongside.

## Timing
- start_i registered at edge N gives busy_o=1 at N+1. The first REWIND pulse, if any, also appears at N+1.
- Each tap costs SETTLE_LEN+WINDOW_LEN+2 cycles. The full sweep costs TAP_COUNT×(SETTLE_LEN+WINDOW_LEN+2) cycles.
- inc_delay_o is always exactly 1 cycle wide.
- tap_o updates in the same cycle that inc_delay_o is high.
- Button edge to pulse: 3 cycles (synchroniser) plus 1 (register).

## Test plan
- **Single window:** lane0 passes taps 10..20, lane1 passes 0..31, with 3 syncs per window and no errors.
  - Required: tap_o lane0=15, lane1=15; done_o=1; fail_o=0; 32 STEP pulses per lane.
- **Two windows:** lane1 passes 3..5 and 20..29.
  - Required: lane1 best = start 20, len 10; final tap 24. A tie case of 2..4 and 8..10 must give tap 3.
- **Error kill:** lane0 passes 10..20, but one lane_sync_err_i arrives during tap 15.
  - Required: best window 10..14 (len 5) versus 16..20 (len 5) resolves to tap 12.
- **No sync:** lane0 receives no sync pulses.
  - Required: fail_o[0]=1, tap_o lane0=0; lane1 calibrates normally.
- **Restart from DONE at tap 15:** issue start_i.
  - Required: 17 REWIND pulses, spaced 2 cycles apart, then the sweep runs.
- **Reset and buttons:** assert reset mid-MEASURE; then press btn_i while busy; then press it in DONE.
  - Required: reset gives all outputs 0 and IDLE. A button while busy gives no pulse. A button in DONE gives 1 pulse and tap+1.
